// File: rtl/cacheline_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adapter_types (package)
//  Purpose  : Shared defaults, address mask and state encoding for the
//             cacheline-to-burst adapter.
//  Revision : 1.0  initial release
// ============================================================================
package cacheline_adapter_types;

    localparam int          BEATS_DEFAULT      = 4;
    localparam int          BEAT_WIDTH_DEFAULT = 64;
    localparam int          LINE_WIDTH         = 256;
    // Clears the byte-in-line offset of a 32-byte cacheline address.
    localparam logic [31:0] LINE_ADDR_MASK     = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_REQ  = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_itf.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_itf (interface)
//  Purpose  : Full-cacheline request/response channel between a cache and
//             the burst adapter.
//  Revision : 1.0  initial release
// ============================================================================
interface cacheline_itf;

    logic [31:0]  addr;
    logic         read;
    logic         write;
    logic [255:0] wdata;
    logic         ready;
    logic [31:0]  raddr;
    logic [255:0] rdata;
    logic         rvalid;

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid
    );

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adapter
//  Purpose  : Converts single full-cacheline reads/writes into BEATS-long
//             bursts on the memory side; one transaction in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module cacheline_adapter
    import cacheline_adapter_types::*;
#(
    parameter int BEATS      = BEATS_DEFAULT,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    cacheline_itf.slave           ufp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int                 c_cnt_w     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_cnt_w-1:0]    r_beat;
    logic [31:0]           r_line_addr;
    logic [LINE_WIDTH-1:0] r_line;

    logic w_accept;
    logic w_hit;
    logic w_last_beat;

    // Handshake qualifiers: request acceptance, matching read beat, final beat.
    assign w_accept    = (r_state == ST_IDLE) && (ufp.read || ufp.write);
    assign w_hit       = bmem_rvalid && (bmem_raddr == r_line_addr);
    assign w_last_beat = (r_beat == c_last_beat);

    // The line buffer doubles as write-data source and read-assembly target.
    assign bmem_addr  = r_line_addr;
    assign bmem_wdata = r_line[int'(r_beat)*BEAT_WIDTH +: BEAT_WIDTH];
    assign ufp.raddr  = r_line_addr;
    assign ufp.rdata  = r_line;

    // Next-state and state-decoded control outputs; write wins over read.
    always_comb begin
        w_state_next = r_state;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        ufp.ready    = 1'b0;
        ufp.rvalid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ufp.ready = 1'b1;
                if (ufp.write) begin
                    w_state_next = ST_WRITE;
                end else if (ufp.read) begin
                    w_state_next = ST_READ_REQ;
                end
            end
            ST_WRITE: begin
                bmem_write = 1'b1;
                if (bmem_ready && w_last_beat) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    w_state_next = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (w_hit && w_last_beat) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                ufp.rvalid   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and beat counter; counter wraps to zero on the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_WRITE: begin
                    if (bmem_ready) begin
                        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    end
                end
                ST_READ_REQ: begin
                    if (bmem_ready) begin
                        r_beat <= '0;
                    end
                end
                ST_READ_WAIT: begin
                    if (w_hit) begin
                        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    end
                end
                default: begin
                    r_beat <= '0;
                end
            endcase
        end
    end

    // Address/line capture on acceptance and read-beat assembly; never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line_addr <= ufp.addr & LINE_ADDR_MASK;
            r_line      <= ufp.wdata;
        end else if ((r_state == ST_READ_WAIT) && w_hit) begin
            r_line[int'(r_beat)*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_adapter
//  Purpose  : Self-checking bench for cacheline_adapter: directed and random
//             line writes/reads against a line/beat reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic        v;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int n_checks = 0;
    int n_err    = 0;

    cacheline_itf ufp_if ();

    cacheline_adapter #(
        .BEATS      (4),
        .BEAT_WIDTH (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ufp         (ufp_if.slave),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One line write; stall_map bit c low-drives bmem_ready in burst cycle c (1-based).
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] stall_map, input bit both);
        logic [63:0] exp_beats [4];
        int idx;
        int cyc;
        for (int i = 0; i < 4; i++) exp_beats[i] = line[i*64 +: 64];
        if (both) $display("note: read and write asserted together (protocol error), expecting write");
        @(negedge clk);
        check("wr_idle_ready", ufp_if.ready, 1'b1);
        ufp_if.addr  = addr;
        ufp_if.wdata = line;
        ufp_if.write = 1'b1;
        ufp_if.read  = both;
        @(negedge clk);
        ufp_if.write = 1'b0;
        ufp_if.read  = 1'b0;
        ufp_if.addr  = $urandom;
        ufp_if.wdata = rand256();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 32) begin
            cyc++;
            bmem_ready = (cyc < 16) ? !stall_map[cyc] : 1'b1;
            check("wr_bmem_write", bmem_write, 1'b1);
            check("wr_bmem_read", bmem_read, 1'b0);
            check("wr_busy_ready", ufp_if.ready, 1'b0);
            check("wr_addr", bmem_addr, addr & 32'hFFFF_FFE0);
            check("wr_beat_data", bmem_wdata, exp_beats[idx]);
            if (bmem_ready) idx++;
            @(negedge clk);
        end
        bmem_ready = 1'b1;
        check("wr_done_ready", ufp_if.ready, 1'b1);
        check("wr_done_write", bmem_write, 1'b0);
    endtask

    // One line read; beats_in holds the four in-order beats for the line.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] beats_in,
                           input int foreign_pos, input bit gap, input int req_stall);
        logic [31:0]  line;
        beat_t        stream [$];
        beat_t        b;
        logic [63:0]  got [$];
        logic [255:0] exp_line;
        int           k;
        line = addr & 32'hFFFF_FFE0;
        for (int i = 0; i < 4; i++) begin
            if (i == foreign_pos) begin
                b.a = line ^ 32'h0000_0020; b.d = rand64(); b.v = 1'b1;
                stream.push_back(b);
            end
            if (gap && i == 1) begin
                b.a = line; b.d = rand64(); b.v = 1'b0;
                stream.push_back(b);
            end
            b.a = line; b.d = beats_in[i*64 +: 64]; b.v = 1'b1;
            stream.push_back(b);
        end
        // Reference: matching valid beats in arrival order, first one lowest.
        foreach (stream[i]) if (stream[i].v && stream[i].a == line) got.push_back(stream[i].d);
        exp_line = '0;
        for (int i = 0; i < 4; i++) exp_line[i*64 +: 64] = got[i];

        @(negedge clk);
        check("rd_idle_ready", ufp_if.ready, 1'b1);
        ufp_if.addr  = addr;
        ufp_if.read  = 1'b1;
        ufp_if.wdata = rand256();
        @(negedge clk);
        ufp_if.read = 1'b0;
        ufp_if.addr = $urandom;
        k = 0;
        while (k < 16) begin
            bmem_ready = (k >= req_stall);
            check("rd_bmem_read", bmem_read, 1'b1);
            check("rd_req_addr", bmem_addr, line);
            check("rd_bmem_write", bmem_write, 1'b0);
            if (bmem_ready) break;
            k++;
            @(negedge clk);
        end
        @(negedge clk);
        foreach (stream[i]) begin
            check("rd_wait_rvalid", ufp_if.rvalid, 1'b0);
            check("rd_wait_read", bmem_read, 1'b0);
            bmem_rvalid = stream[i].v;
            bmem_raddr  = stream[i].a;
            bmem_rdata  = stream[i].d;
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = $urandom;
        bmem_rdata  = rand64();
        check("rd_rvalid", ufp_if.rvalid, 1'b1);
        check("rd_raddr", ufp_if.raddr, line);
        check("rd_rdata", ufp_if.rdata, exp_line);
        @(negedge clk);
        check("rd_rvalid_once", ufp_if.rvalid, 1'b0);
        check("rd_back_idle", ufp_if.ready, 1'b1);
    endtask

    // Read interrupted by reset after two beats; outputs must idle at once.
    task automatic reset_mid_read(input logic [31:0] addr);
        logic [31:0] line;
        line = addr & 32'hFFFF_FFE0;
        @(negedge clk);
        ufp_if.addr = addr;
        ufp_if.read = 1'b1;
        @(negedge clk);
        ufp_if.read = 1'b0;
        bmem_ready  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = line; bmem_rdata = rand64();
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_rd_ready", ufp_if.ready, 1'b1);
        check("rst_rd_rvalid", ufp_if.rvalid, 1'b0);
        check("rst_rd_read", bmem_read, 1'b0);
        check("rst_rd_write", bmem_write, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1 || i == 2) begin
                bmem_rvalid = 1'b1; bmem_raddr = line; bmem_rdata = rand64();
            end else begin
                bmem_rvalid = 1'b0;
            end
            @(negedge clk);
            check("rst_no_stray_rvalid", ufp_if.rvalid, 1'b0);
        end
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        ufp_if.addr  = '0;
        ufp_if.read  = 1'b0;
        ufp_if.write = 1'b0;
        ufp_if.wdata = '0;
        bmem_ready   = 1'b1;
        bmem_raddr   = '0;
        bmem_rdata   = '0;
        bmem_rvalid  = 1'b0;
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", ufp_if.ready, 1'b1);
        check("reset_rvalid", ufp_if.rvalid, 1'b0);
        check("reset_bmem_read", bmem_read, 1'b0);
        check("reset_bmem_write", bmem_write, 1'b0);
        rst = 1'b1;

        // Basic write, no stalls.
        do_write(32'h0000_1234,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                 16'h0000, 1'b0);

        // Basic read of four beats A..D.
        do_read(32'h8000_0040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                -1, 1'b0, 0);

        // Memory stalls in burst cycles 2 and 3.
        do_write(32'h0000_5A60, rand256(), 16'b0000_0000_0000_1100, 1'b0);

        // Foreign-address beat and an invalid gap interleaved.
        do_read(32'h1234_5678, rand256(), 2, 1'b1, 1);

        // Stray rvalid while idle must not disturb anything.
        @(negedge clk);
        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0100; bmem_rdata = rand64();
        @(negedge clk);
        bmem_rvalid = 1'b0;
        check("idle_rvalid_ignored", ufp_if.rvalid, 1'b0);
        check("idle_ready_kept", ufp_if.ready, 1'b1);
        do_read(32'h0000_0100, rand256(), 0, 1'b0, 0);

        // Reset during read, then a clean read.
        reset_mid_read(32'h4000_0080);
        do_read(32'h4000_0080, rand256(), -1, 1'b0, 0);

        // Reset during a write burst.
        @(negedge clk);
        ufp_if.addr = 32'h0000_0200; ufp_if.wdata = rand256(); ufp_if.write = 1'b1;
        @(negedge clk);
        ufp_if.write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wr_write", bmem_write, 1'b0);
        check("rst_wr_ready", ufp_if.ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous read and write behaves as a write.
        do_write(32'hCAFE_0010, rand256(), 16'h0000, 1'b1);

        // Randomized mix.
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write($urandom, rand256(), 16'($urandom & 32'h0000_01FE),
                         ($urandom_range(0, 3) == 0));
            end else begin
                do_read($urandom, rand256(), int'($urandom_range(0, 4)) - 1,
                        ($urandom_range(0, 1) == 1), int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
